adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pipe.sv | 118 +++++++++++
 tb/tb_adder_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: adder/subtractor with a STAGES-deep sliced carry chain and valid/ready flow control.
// Define ADDER_PIPE_SAT_EN to saturate sum_o on overflow instead of wrapping modulo 2^WIDTH.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             overflow_o
);
    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > 8 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES (1..8)");
    end

    logic en;
    assign en = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    // Stage k adds slice k; only the not-yet-consumed operand slices travel onward.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SW;
        logic [RW-1:0]       a_d;
        logic [RW-1:0]       bx_d;
        logic [(k+1)*SW-1:0] sw;
        logic [SW:0]         sl;
        logic                ci;
        logic                sub_d;
        logic                sgn_d;
        logic                v_d;
        if (k == 0) begin : g_in
            assign a_d   = a_i;
            assign bx_d  = sub_i ? ~b_i : b_i;
            assign ci    = sub_i;
            assign sub_d = sub_i;
            assign sgn_d = signed_i;
            assign v_d   = in_valid_i;
            assign sw    = sl[SW-1:0];
        end else begin : g_chain
            assign a_d   = g_st[k-1].g_reg.a_q;
            assign bx_d  = g_st[k-1].g_reg.bx_q;
            assign ci    = g_st[k-1].g_reg.c_q;
            assign sub_d = g_st[k-1].g_reg.sub_q;
            assign sgn_d = g_st[k-1].g_reg.sgn_q;
            assign v_d   = g_st[k-1].g_reg.v_q;
            assign sw    = {sl[SW-1:0], g_st[k-1].g_reg.s_q};
        end
        assign sl = {1'b0, a_d[SW-1:0]} + {1'b0, bx_d[SW-1:0]} + {{SW{1'b0}}, ci};
        if (k < STAGES - 1) begin : g_reg
            logic [RW-SW-1:0]    a_q;
            logic [RW-SW-1:0]    bx_q;
            logic [(k+1)*SW-1:0] s_q;
            logic                v_q;
            logic                sub_q;
            logic                sgn_q;
            logic                c_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q   <= 1'b0;
                    a_q   <= '0;
                    bx_q  <= '0;
                    s_q   <= '0;
                    sub_q <= 1'b0;
                    sgn_q <= 1'b0;
                    c_q   <= 1'b0;
                end else if (en) begin
                    v_q <= v_d;
                    if (v_d) begin
                        a_q   <= a_d[RW-1:SW];
                        bx_q  <= bx_d[RW-1:SW];
                        s_q   <= sw;
                        sub_q <= sub_d;
                        sgn_q <= sgn_d;
                        c_q   <= sl[SW];
                    end
                end
            end
        end else begin : g_out
            logic             u_ovf;
            logic             s_ovf;
            logic             ovf;
            logic [WIDTH-1:0] res;
            // Subtraction borrows exactly when the inverted-B carry-out is clear.
            assign u_ovf = sl[SW] ^ sub_d;
            assign s_ovf = (a_d[SW-1] == bx_d[SW-1]) && (sw[WIDTH-1] != a_d[SW-1]);
            assign ovf   = sgn_d ? s_ovf : u_ovf;
`ifdef ADDER_PIPE_SAT_EN
            assign res = !ovf ? sw :
                         sgn_d ? {a_d[SW-1], {(WIDTH-1){~a_d[SW-1]}}} : {WIDTH{~sub_d}};
`else
            assign res = sw;
`endif
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_valid_o <= 1'b0;
                    sum_o       <= '0;
                    overflow_o  <= 1'b0;
                end else if (en) begin
                    out_valid_o <= v_d;
                    if (v_d) begin
                        sum_o      <= res;
                        overflow_o <= ovf;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: randomized and directed checks of adder_pipe against an arithmetic reference model.
module tb_adder_pipe;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         sub_i = 1'b0;
    logic         signed_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [W-1:0] sum_o;
    logic         overflow_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int npop = 0;
    logic [W:0] q[$];

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .signed_i(signed_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sum_o(sum_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exact integer result, then range test; saturation is a clamp to the representable range.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic sgn);
        longint r, lo, hi;
        logic ov;
        logic [W-1:0] s;
        if (sgn) begin
            r  = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
            lo = -(longint'(1) << (W - 1));
            hi = (longint'(1) << (W - 1)) - 1;
        end else begin
            r  = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
            lo = 0;
            hi = (longint'(1) << W) - 1;
        end
        ov = (r < lo) || (r > hi);
        s  = W'(r);
`ifdef ADDER_PIPE_SAT_EN
        if (ov) s = W'((r > hi) ? hi : lo);
`endif
        return {ov, s};
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (in_valid_i && in_ready_o) q.push_back(model(a_i, b_i, sub_i, signed_i));
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) check("spurious_out", 64'(out_valid_o), 64'(0));
                else begin
                    check("result", 64'({overflow_o, sum_o}), 64'(q.pop_front()));
                    npop++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic sgn);
        int n = 0;
        in_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        sub_i = sub;
        signed_i = sgn;
        @(negedge clk_i);
        while (!in_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_ready_o) check("send_timeout", 64'(in_ready_o), 64'(1));
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("drain", 64'(q.size()), 64'(0));
        step();
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic sgn, input logic [W:0] exp);
        send(a, b, sub, sgn);
        drain();
        check(tag, 64'({overflow_o, sum_o}), 64'(exp));
    endtask

    initial begin
        int lat, p0, t0;
        logic [W-1:0] held;
        bit done;
        #1;
        check("rst_valid", 64'(out_valid_o), 64'(0));
        check("rst_sum", 64'({overflow_o, sum_o}), 64'(0));
        check("rst_ready", 64'(in_ready_o), 64'(1));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        send(8'd200, 8'd100, 1'b0, 1'b0);
        lat = 1;
        @(negedge clk_i);
        while (!out_valid_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        check("latency", 64'(lat), 64'(S));
        drain();
`ifdef ADDER_PIPE_SAT_EN
        check("u200+100", 64'({overflow_o, sum_o}), 64'(9'h1FF));
        directed("s100+100", 8'd100, 8'd100, 1'b0, 1'b1, 9'h17F);
        directed("s-128-1", 8'h80, 8'h01, 1'b1, 1'b1, 9'h180);
        directed("u5-10", 8'd5, 8'd10, 1'b1, 1'b0, 9'h100);
`else
        check("u200+100", 64'({overflow_o, sum_o}), 64'(9'h12C));
        directed("s100+100", 8'd100, 8'd100, 1'b0, 1'b1, 9'h1C8);
        directed("s-128-1", 8'h80, 8'h01, 1'b1, 1'b1, 9'h17F);
        directed("u5-10", 8'd5, 8'd10, 1'b1, 1'b0, 9'h1FB);
`endif
        directed("u10-5", 8'd10, 8'd5, 1'b1, 1'b0, 9'h005);
        directed("s3-5", 8'd3, 8'd5, 1'b1, 1'b1, 9'h0FE);

        p0 = npop;
        t0 = cyc;
        repeat (100) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        check("b2b_cycles", 64'(cyc - t0), 64'(100));
        drain();
        check("b2b_count", 64'(npop - p0), 64'(100));

        p0 = npop;
        done = 1'b0;
        fork
            begin
                repeat (60) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                done = 1'b1;
            end
            while (!done) begin
                step();
                out_ready_i = 1'($urandom_range(0, 1));
            end
        join
        out_ready_i = 1'b1;
        drain();
        check("rand_ready_count", 64'(npop - p0), 64'(60));

        p0 = npop;
        out_ready_i = 1'b0;
        send(8'd17, 8'd40, 1'b0, 1'b0);
        send(8'd90, 8'd91, 1'b1, 1'b1);
        held = sum_o;
        repeat (3) begin
            @(negedge clk_i);
            check("stall_ready", 64'(in_ready_o), 64'(0));
            check("stall_valid", 64'(out_valid_o), 64'(1));
            check("stall_sum", 64'(sum_o), 64'(8'd57));
            check("stall_stable", 64'(sum_o), 64'(held));
        end
        step();
        out_ready_i = 1'b1;
        drain();
        check("stall_count", 64'(npop - p0), 64'(2));

        out_ready_i = 1'b0;
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid_o), 64'(0));
        check("arst_sum", 64'({overflow_o, sum_o}), 64'(0));
        check("arst_ready", 64'(in_ready_o), 64'(1));
        q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            check("post_rst_valid", 64'(out_valid_o), 64'(0));
        end
        step();
        p0 = npop;
        directed("post_rst_beat", 8'd250, 8'd6, 1'b0, 1'b0, model(8'd250, 8'd6, 1'b0, 1'b0));
        check("post_rst_count", 64'(npop - p0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
